// File: rtl/ic_pkg.sv
// Shared types and default sizing for the instruction-cache data path.
package ic_pkg;

  localparam int unsigned IC_WAYS       = 2;
  localparam int unsigned IC_LINES      = 256;
  localparam int unsigned IC_WORDS      = 4;
  localparam int unsigned IC_DATA_W     = 16;
  localparam int unsigned IC_BEAT_WORDS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } ic_fill_state_e;

  // Index widths must stay at least one bit even for single-entry dimensions.
  function automatic int unsigned ic_max1(int unsigned v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/ic_data_bank_mem.sv
// Behavioural simple dual-port array: beat-wide write, word-wide registered read.
// Kept separate so a vendor macro can replace it without touching the control logic.
module ic_data_bank_mem
  import ic_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ROW_WORDS = 2,
  parameter int unsigned WORD_BITS = 16,
  localparam int unsigned ADDR_W   = ic_max1($clog2(DEPTH)),
  localparam int unsigned OFF_W    = ic_max1($clog2(ROW_WORDS))
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_wr_en,
  input  logic [ADDR_W-1:0]              i_wr_addr,
  input  logic [ROW_WORDS*WORD_BITS-1:0] i_wr_data,
  input  logic                           i_rd_en,
  input  logic [ADDR_W-1:0]              i_rd_addr,
  input  logic [OFF_W-1:0]               i_rd_off,
  output logic [WORD_BITS-1:0]           o_rd_q
);

  logic [ROW_WORDS*WORD_BITS-1:0] r_mem [DEPTH];
  logic [WORD_BITS-1:0]           r_rd_q;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read returns pre-write contents on an address clash; the caller forwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_q <= '0;
    end else if (i_rd_en) begin
      r_rd_q <= r_mem[i_rd_addr][i_rd_off*WORD_BITS +: WORD_BITS];
    end
  end

  assign o_rd_q = r_rd_q;

endmodule

// File: rtl/ic_data_bank.sv
// Instruction-cache data bank: burst fill sequencer, 1-cycle word reads, write-to-read forwarding.
// Optional per-word even parity with rd_perr output when IC_DATA_PARITY_EN is defined.
module ic_data_bank
  import ic_pkg::*;
#(
  parameter int unsigned WAYS       = IC_WAYS,
  parameter int unsigned LINES      = IC_LINES,
  parameter int unsigned WORDS      = IC_WORDS,
  parameter int unsigned DATA_W     = IC_DATA_W,
  parameter int unsigned BEAT_WORDS = IC_BEAT_WORDS,
  localparam int unsigned WAY_W     = ic_max1($clog2(WAYS)),
  localparam int unsigned LINE_W    = $clog2(LINES),
  localparam int unsigned WORD_W    = $clog2(WORDS),
  localparam int unsigned BEATS     = WORDS / BEAT_WORDS,
  localparam int unsigned BEAT_W    = ic_max1($clog2(BEATS))
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_en,
  input  logic [WAY_W-1:0]             rd_way,
  input  logic [LINE_W-1:0]            rd_line,
  input  logic [WORD_W-1:0]            rd_word,
  output logic                         rd_valid,
  output logic [DATA_W-1:0]            rd_data,
  input  logic                         fill_start,
  input  logic [WAY_W-1:0]             fill_way,
  input  logic [LINE_W-1:0]            fill_line,
  input  logic                         fill_abort,
  input  logic                         fill_valid,
  input  logic [DATA_W*BEAT_WORDS-1:0] fill_data,
  output logic                         fill_ready,
  output logic                         fill_busy,
  output logic                         fill_done
`ifdef IC_DATA_PARITY_EN
  ,
  output logic                         rd_perr
`endif
);

  localparam int unsigned OFF_W  = ic_max1($clog2(BEAT_WORDS));
  localparam int unsigned DEPTH  = WAYS * LINES * BEATS;
  localparam int unsigned ADDR_W = ic_max1($clog2(DEPTH));
`ifdef IC_DATA_PARITY_EN
  localparam int unsigned WORD_BITS = DATA_W + 1;
`else
  localparam int unsigned WORD_BITS = DATA_W;
`endif

  ic_fill_state_e r_state, w_state_nxt;
  logic [WAY_W-1:0]  r_way;
  logic [LINE_W-1:0] r_line;
  logic [BEAT_W-1:0] r_beat_cnt, w_beat_nxt;

  logic                            w_wr_en;
  logic [ADDR_W-1:0]               w_wr_addr;
  logic [BEAT_WORDS*WORD_BITS-1:0] w_wr_data;
  logic [BEAT_W-1:0]               w_rd_beat;
  logic [OFF_W-1:0]                w_rd_off;
  logic [ADDR_W-1:0]               w_rd_addr;
  logic                            w_collide;
  logic [WORD_BITS-1:0]            w_mem_q;

  logic                         r_rd_valid;
  logic                         r_fwd_hit;
  logic [DATA_W*BEAT_WORDS-1:0] r_fwd_beat;
  logic [OFF_W-1:0]             r_fwd_off;

  // Fill sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    unique case (r_state)
      IDLE: begin
        if (fill_start) begin
          w_state_nxt = FILL;
          w_beat_nxt  = '0;
        end
      end
      FILL: begin
        if (fill_abort) begin
          w_state_nxt = IDLE;
          w_beat_nxt  = '0;
        end else if (fill_valid) begin
          if (r_beat_cnt == BEAT_W'(BEATS - 1)) begin
            w_state_nxt = DONE;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_way      <= '0;
      r_line     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      if (r_state == IDLE && fill_start) begin
        r_way  <= fill_way;
        r_line <= fill_line;
      end
    end
  end

  assign fill_ready = (r_state == FILL);
  assign fill_busy  = (r_state != IDLE);
  assign fill_done  = (r_state == DONE);

  // An aborting beat is dropped, so abort gates the write.
  assign w_wr_en   = (r_state == FILL) && fill_valid && !fill_abort;
  assign w_wr_addr = ADDR_W'(((32'(r_way) * LINES) + 32'(r_line)) * BEATS + 32'(r_beat_cnt));

  always_comb begin
    w_wr_data = '0;
    for (int i = 0; i < BEAT_WORDS; i++) begin
`ifdef IC_DATA_PARITY_EN
      w_wr_data[i*WORD_BITS +: WORD_BITS] = {^fill_data[i*DATA_W +: DATA_W],
                                             fill_data[i*DATA_W +: DATA_W]};
`else
      w_wr_data[i*WORD_BITS +: WORD_BITS] = fill_data[i*DATA_W +: DATA_W];
`endif
    end
  end

  assign w_rd_beat = BEAT_W'(32'(rd_word) / BEAT_WORDS);
  assign w_rd_off  = OFF_W'(32'(rd_word) % BEAT_WORDS);
  assign w_rd_addr = ADDR_W'(((32'(rd_way) * LINES) + 32'(rd_line)) * BEATS + 32'(w_rd_beat));
  assign w_collide = rd_en && w_wr_en && (rd_way == r_way) && (rd_line == r_line) &&
                     (w_rd_beat == r_beat_cnt);

  ic_data_bank_mem #(
    .DEPTH     (DEPTH),
    .ROW_WORDS (BEAT_WORDS),
    .WORD_BITS (WORD_BITS)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (rd_en),
    .i_rd_addr (w_rd_addr),
    .i_rd_off  (w_rd_off),
    .o_rd_q    (w_mem_q)
  );

  // Forward path state only moves on a read, so rd_data holds when rd_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_fwd_hit  <= 1'b0;
      r_fwd_beat <= '0;
      r_fwd_off  <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_fwd_hit <= w_collide;
      end
      if (w_collide) begin
        r_fwd_beat <= fill_data;
        r_fwd_off  <= w_rd_off;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_fwd_hit ? r_fwd_beat[r_fwd_off*DATA_W +: DATA_W] : w_mem_q[DATA_W-1:0];

`ifdef IC_DATA_PARITY_EN
  // Forwarded words get freshly generated parity, which cannot mismatch.
  assign rd_perr = r_rd_valid && !r_fwd_hit && (^w_mem_q);
`endif

endmodule

// File: tb/tb_ic_data_bank.sv
// Scoreboard bench for ic_data_bank: fills, forwarding, abort, async reset, optional parity.
module tb_ic_data_bank;
  import ic_pkg::*;

  localparam int unsigned DW = IC_DATA_W;
  localparam int unsigned BW = IC_BEAT_WORDS;

  logic           clk = 1'b0;
  logic           rst;
  logic           rd_en;
  logic [0:0]     rd_way;
  logic [7:0]     rd_line;
  logic [1:0]     rd_word;
  logic           rd_valid;
  logic [DW-1:0]  rd_data;
  logic           fill_start;
  logic [0:0]     fill_way;
  logic [7:0]     fill_line;
  logic           fill_abort;
  logic           fill_valid;
  logic [DW*BW-1:0] fill_data;
  logic           fill_ready;
  logic           fill_busy;
  logic           fill_done;
`ifdef IC_DATA_PARITY_EN
  logic           rd_perr;
`endif

  ic_data_bank dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_way     (rd_way),
    .rd_line    (rd_line),
    .rd_word    (rd_word),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fill_start (fill_start),
    .fill_way   (fill_way),
    .fill_line  (fill_line),
    .fill_abort (fill_abort),
    .fill_valid (fill_valid),
    .fill_data  (fill_data),
    .fill_ready (fill_ready),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done)
`ifdef IC_DATA_PARITY_EN
    ,
    .rd_perr    (rd_perr)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic [DW-1:0] mdl [2][256][4];
  logic [DW-1:0] sb_q [$];
  int            tb_way;
  int            tb_line;
  int            tb_beat;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock; the read issued before this edge must appear right after it.
  task automatic cyc();
    logic exp_v;
    exp_v = rd_en;
    @(posedge clk);
    #1;
    check_eq("rd_valid", 32'(rd_valid), 32'(exp_v));
    if (exp_v) begin
      if (sb_q.size() == 0) check_eq("sb_depth", sb_q.size(), 1);
      else check_eq("rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
    end
  endtask

  task automatic idle_in();
    rd_en = 0; rd_way = 0; rd_line = 0; rd_word = 0;
    fill_start = 0; fill_way = 0; fill_line = 0;
    fill_abort = 0; fill_valid = 0; fill_data = '0;
  endtask

  task automatic rd_req(input int way, input int line, input int word);
    rd_en   = 1'b1;
    rd_way  = 1'(way);
    rd_line = 8'(line);
    rd_word = 2'(word);
    sb_q.push_back(mdl[way][line][word]);
  endtask

  task automatic start_fill(input int way, input int line);
    fill_start = 1'b1;
    fill_way   = 1'(way);
    fill_line  = 8'(line);
    cyc();
    fill_start = 1'b0;
    check_eq("busy_after_start", 32'(fill_busy), 1);
    check_eq("ready_in_fill", 32'(fill_ready), 1);
    check_eq("done_in_fill", 32'(fill_done), 0);
    tb_way = way; tb_line = line; tb_beat = 0;
  endtask

  // Drive an accepted beat and apply it to the model before any same-cycle read.
  task automatic put_beat(input logic [31:0] d);
    logic [31:0] dv;
    dv = d;
    fill_valid = 1'b1;
    fill_data  = dv;
    for (int i = 0; i < int'(BW); i++) begin
      mdl[tb_way][tb_line][tb_beat*int'(BW)+i] = dv[i*DW +: DW];
    end
    tb_beat++;
  endtask

  task automatic end_fill();
    fill_valid = 1'b0;
    check_eq("done_pulse", 32'(fill_done), 1);
    check_eq("ready_in_done", 32'(fill_ready), 0);
    check_eq("busy_in_done", 32'(fill_busy), 1);
    cyc();
    check_eq("done_clear", 32'(fill_done), 0);
    check_eq("busy_clear", 32'(fill_busy), 0);
    check_eq("ready_idle", 32'(fill_ready), 0);
  endtask

  task automatic full_fill(input int way, input int line, input logic [31:0] b0,
                           input logic [31:0] b1);
    start_fill(way, line);
    put_beat(b0);
    cyc();
    put_beat(b1);
    cyc();
    end_fill();
  endtask

  task automatic read_line(input int way, input int line);
    for (int w = 0; w < 4; w++) begin
      rd_req(way, line, w);
      cyc();
    end
    rd_en = 1'b0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_in();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rd_valid", 32'(rd_valid), 0);
    check_eq("rst_rd_data", 32'(rd_data), 0);
    check_eq("rst_fill_ready", 32'(fill_ready), 0);
    check_eq("rst_fill_busy", 32'(fill_busy), 0);
    check_eq("rst_fill_done", 32'(fill_done), 0);
    rst = 1'b0;
    cyc();

    // Basic fill and read-back
    full_fill(1, 5, 32'h0001_0000, 32'h0003_0002);
    read_line(1, 5);

    // Forwarding: hit on same way/line/beat, miss on other way, miss on other beat
    full_fill(1, 7, 32'h1113_1112, 32'h1115_1114);
    start_fill(0, 7);
    put_beat(32'h0099_0098);
    cyc();
    put_beat(32'h00BB_00AA);
    rd_req(0, 7, 3);
    cyc();
    rd_en = 1'b0;
    end_fill();
    check_eq("rd_hold_fwd", 32'(rd_data), 32'h00BB);

    start_fill(0, 7);
    put_beat(32'h0077_0066);
    cyc();
    put_beat(32'h00DD_00CC);
    rd_req(1, 7, 3);
    cyc();
    rd_en = 1'b0;
    end_fill();
    check_eq("rd_other_way", 32'(rd_data), 32'h1115);

    start_fill(0, 7);
    put_beat(32'h0055_0044);
    rd_req(0, 7, 3);
    cyc();
    put_beat(32'h0033_0022);
    rd_req(0, 7, 2);
    cyc();
    rd_en = 1'b0;
    end_fill();
    read_line(0, 7);

    // Gapped beats; a stray fill_start mid-fill must be ignored
    start_fill(0, 9);
    put_beat(32'h0909_0908);
    cyc();
    fill_valid = 1'b0;
    fill_start = 1'b1;
    fill_way   = 1'b1;
    fill_line  = 8'd9;
    for (int k = 0; k < 2; k++) begin
      cyc();
      check_eq("gap_ready", 32'(fill_ready), 1);
      check_eq("gap_busy", 32'(fill_busy), 1);
      check_eq("gap_done", 32'(fill_done), 0);
    end
    fill_start = 1'b0;
    put_beat(32'h0B0B_0B0A);
    cyc();
    end_fill();
    read_line(0, 9);

    // Abort together with beat 1: that beat is dropped, beat 0 stays
    full_fill(1, 20, 32'h00A1_00A0, 32'h00A3_00A2);
    start_fill(1, 20);
    put_beat(32'h00B1_00B0);
    cyc();
    fill_valid = 1'b1;
    fill_data  = 32'h00B3_00B2;
    fill_abort = 1'b1;
    cyc();
    fill_valid = 1'b0;
    fill_abort = 1'b0;
    check_eq("abort_busy", 32'(fill_busy), 0);
    check_eq("abort_ready", 32'(fill_ready), 0);
    check_eq("abort_done", 32'(fill_done), 0);
    start_fill(0, 21);
    put_beat(32'h2121_2120);
    cyc();
    put_beat(32'h2323_2322);
    cyc();
    end_fill();
    read_line(1, 20);
    read_line(0, 21);

    // Asynchronous reset mid-fill with a read outstanding
    start_fill(0, 30);
    put_beat(32'h3131_3130);
    cyc();
    fill_valid = 1'b0;
    rd_req(0, 30, 1);
    cyc();
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_rd_valid", 32'(rd_valid), 0);
    check_eq("arst_rd_data", 32'(rd_data), 0);
    check_eq("arst_busy", 32'(fill_busy), 0);
    check_eq("arst_ready", 32'(fill_ready), 0);
    check_eq("arst_done", 32'(fill_done), 0);
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    check_eq("post_rst_done", 32'(fill_done), 0);
    rd_req(0, 30, 0);
    cyc();
    rd_req(0, 30, 1);
    cyc();
    rd_en = 1'b0;
    cyc();
    full_fill(0, 30, 32'h3333_3332, 32'h3535_3534);
    read_line(0, 30);

`ifdef IC_DATA_PARITY_EN
    full_fill(1, 40, 32'h4141_4140, 32'h4343_4342);
    dut.u_mem.r_mem[(256 + 40) * 2][0] = ~dut.u_mem.r_mem[(256 + 40) * 2][0];
    mdl[1][40][0] = mdl[1][40][0] ^ 16'h0001;
    rd_req(1, 40, 0);
    cyc();
    check_eq("perr_flag", 32'(rd_perr), 1);
    rd_req(1, 40, 1);
    cyc();
    check_eq("perr_clean", 32'(rd_perr), 0);
    rd_en = 1'b0;
    cyc();
    check_eq("perr_idle", 32'(rd_perr), 0);
`endif

    check_eq("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
